// File: rtl/flow_table_ctrl_if.sv
// Signal bundle for flow_table_ctrl: two lookup requesters, lookup response,
// PS entry-write command, and the flow-table lookup/write ports.
interface flow_table_ctrl_if;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned ID_W   = 16;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned DATA_W = 32;

    logic              req0_valid;
    logic              req0_ready;
    logic [KEY_W-1:0]  req0_key;
    logic              req1_valid;
    logic              req1_ready;
    logic [KEY_W-1:0]  req1_key;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_src;
    logic              rsp_hit;
    logic [ID_W-1:0]   rsp_id;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [IDX_W-1:0]  cfg_index;
    logic [KEY_W-1:0]  cfg_key;
    logic [ID_W-1:0]   cfg_id;
    logic              cfg_entry_valid;

    logic [KEY_W-1:0]  ft_flow_key;
    logic              ft_flow_key_valid;
    logic              ft_flow_hit;
    logic [ID_W-1:0]   ft_flow_id;
    logic [IDX_W-1:0]  ft_waddr;
    logic [DATA_W-1:0] ft_wdata;
    logic              ft_we;
    logic              busy;

    modport slave (
        input  req0_valid, req0_key, req1_valid, req1_key, rsp_ready,
               cfg_valid, cfg_index, cfg_key, cfg_id, cfg_entry_valid,
               ft_flow_hit, ft_flow_id,
        output req0_ready, req1_ready, rsp_valid, rsp_src, rsp_hit, rsp_id,
               cfg_ready, ft_flow_key, ft_flow_key_valid, ft_waddr, ft_wdata,
               ft_we, busy
    );

    modport master (
        output req0_valid, req0_key, req1_valid, req1_key, rsp_ready,
               cfg_valid, cfg_index, cfg_key, cfg_id, cfg_entry_valid,
               ft_flow_hit, ft_flow_id,
        input  req0_ready, req1_ready, rsp_valid, rsp_src, rsp_hit, rsp_id,
               cfg_ready, ft_flow_key, ft_flow_key_valid, ft_waddr, ft_wdata,
               ft_we, busy
    );
endinterface

// File: rtl/flow_table_ctrl.sv
// Flow-table controller: round-robin lookup arbitration between two requesters and
// 5-beat PS entry writes. Optional hit/miss statistics under FLOW_TABLE_STATS_EN.
module flow_table_ctrl #(
    parameter int unsigned LOOKUP_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    flow_table_ctrl_if.slave bus
`ifdef FLOW_TABLE_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned ID_W   = 16;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BEAT_W = 3;
    localparam int unsigned WCNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(4);
    localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'(LOOKUP_LAT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, WRITE} state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              src_q, src_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              key_valid_q, key_valid_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_src_q, rsp_src_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [KEY_W-1:0]  cfg_key_q, cfg_key_d;
    logic [ID_W-1:0]   cfg_id_q, cfg_id_d;
    logic              cfg_ev_q, cfg_ev_d;
    logic [IDX_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              busy_q, busy_d;
    logic              grant0_c, grant1_c, cfg_ready_c;

    // Beats 0..3 carry the key low word first; beat 4 carries {valid, id}.
    function automatic logic [DATA_W-1:0] beat_word(input logic [KEY_W-1:0]  key,
                                                    input logic [ID_W-1:0]   id,
                                                    input logic              ev,
                                                    input logic [BEAT_W-1:0] beat);
        if (beat == LAST_BEAT) return {{(DATA_W-ID_W-1){1'b0}}, ev, id};
        return key[{beat[1:0], 5'd0} +: DATA_W];
    endfunction

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        src_d       = src_q;
        key_d       = key_q;
        wcnt_d      = wcnt_q;
        rsp_src_d   = rsp_src_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_id_d    = rsp_id_q;
        cfg_key_d   = cfg_key_q;
        cfg_id_d    = cfg_id_q;
        cfg_ev_d    = cfg_ev_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        beat_d      = beat_q;
        grant0_c    = 1'b0;
        grant1_c    = 1'b0;
        cfg_ready_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                cfg_ready_c = rst_n;
                // Config always wins; otherwise rr_q names the preferred requester.
                if (!bus.cfg_valid && rst_n) begin
                    grant0_c = bus.req0_valid && (!rr_q || !bus.req1_valid);
                    grant1_c = bus.req1_valid && ( rr_q || !bus.req0_valid);
                end
                if (bus.cfg_valid) begin
                    state_d   = WRITE;
                    cfg_key_d = bus.cfg_key;
                    cfg_id_d  = bus.cfg_id;
                    cfg_ev_d  = bus.cfg_entry_valid;
                    waddr_d   = bus.cfg_index;
                    wdata_d   = beat_word(bus.cfg_key, bus.cfg_id, bus.cfg_entry_valid, '0);
                    beat_d    = '0;
                end else if (grant0_c || grant1_c) begin
                    state_d = ISSUE;
                    src_d   = grant1_c;
                    key_d   = grant1_c ? bus.req1_key : bus.req0_key;
                    rr_d    = !grant1_c;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                if (wcnt_q == LAST_WAIT) begin
                    state_d   = RESP;
                    wcnt_d    = '0;
                    rsp_src_d = src_q;
                    rsp_hit_d = bus.ft_flow_hit;
                    rsp_id_d  = bus.ft_flow_hit ? bus.ft_flow_id : '0;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            WRITE: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                    wdata_d = beat_word(cfg_key_q, cfg_id_q, cfg_ev_q, beat_q + BEAT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        key_valid_d = (state_d == ISSUE);
        rsp_valid_d = (state_d == RESP);
        we_d        = (state_d == WRITE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            src_q       <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            wcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_id_q    <= '0;
            cfg_key_q   <= '0;
            cfg_id_q    <= '0;
            cfg_ev_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            beat_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            src_q       <= src_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            wcnt_q      <= wcnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_src_q   <= rsp_src_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_id_q    <= rsp_id_d;
            cfg_key_q   <= cfg_key_d;
            cfg_id_q    <= cfg_id_d;
            cfg_ev_q    <= cfg_ev_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            beat_q      <= beat_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req0_ready        = grant0_c;
    assign bus.req1_ready        = grant1_c;
    assign bus.cfg_ready         = cfg_ready_c;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_src           = rsp_src_q;
    assign bus.rsp_hit           = rsp_hit_q;
    assign bus.rsp_id            = rsp_id_q;
    assign bus.ft_flow_key       = key_q;
    assign bus.ft_flow_key_valid = key_valid_q;
    assign bus.ft_waddr          = waddr_q;
    assign bus.ft_wdata          = wdata_q;
    assign bus.ft_we             = we_q;
    assign bus.busy              = busy_q;

`ifdef FLOW_TABLE_STATS_EN
    localparam int unsigned CNT_W = 32;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Count once per response, on the WAIT->RESP sample; clear beats increment.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (stats_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (state_q == WAIT && state_d == RESP) begin
            if (bus.ft_flow_hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: doc/flow_table_ctrl.md
FLOW_TABLE_CTRL -- requirements
Module: flow_table_ctrl

Interface
REQ-001 SHALL have parameter LOOKUP_LAT, default 3, cycles from ft_flow_key_valid high to ft_flow_hit/ft_flow_id valid.
REQ-002 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous, active-low; one clock, no other reset.
REQ-003 SHALL have req0_valid in 1, req0_ready out 1, req0_key in 128: lookup requester 0.
REQ-004 SHALL have req1_valid in 1, req1_ready out 1, req1_key in 128: lookup requester 1.
REQ-005 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_src out 1, rsp_hit out 1, rsp_id out 16: lookup result, rsp_src = 0 or 1 for the requester.
REQ-006 SHALL have cfg_valid in 1, cfg_ready out 1, cfg_index in 8, cfg_key in 128, cfg_id in 16, cfg_entry_valid in 1: PS entry-write command.
REQ-007 SHALL have ft_flow_key out 128, ft_flow_key_valid out 1, ft_flow_hit in 1, ft_flow_id in 16: flow table lookup port.
REQ-008 SHALL have ft_waddr out 8, ft_wdata out 32, ft_we out 1: flow table write port; busy out 1, high when state is not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, WRITE.
REQ-010 In IDLE, cfg_valid SHALL have strict priority over lookups: cfg_ready=1, req*_ready=0.
REQ-011 In IDLE with no cfg_valid, SHALL grant one requester round-robin: rr pointer names the preferred requester; the other is granted only if the preferred one is not valid; after a grant, pointer = the other requester; pointer resets to 0.
REQ-012 Only the granted requester's ready SHALL be high, combinationally, only in IDLE; all ready signals SHALL be low in every other state.
REQ-013 On req accept, SHALL register key and source and go to ISSUE; in ISSUE, ft_flow_key_valid=1 for exactly one cycle with ft_flow_key = registered key, then go to WAIT.
REQ-014 ft_flow_key SHALL hold its value outside ISSUE; at most one lookup SHALL be outstanding.
REQ-015 WAIT SHALL count LOOKUP_LAT-1 cycles after ISSUE, then sample ft_flow_hit/ft_flow_id in the cycle LOOKUP_LAT after ISSUE into rsp_hit/rsp_id and go to RESP.
REQ-016 In RESP, rsp_valid=1 and rsp_* SHALL stay stable until rsp_valid&&rsp_ready; then go to IDLE. Latency is accept cycle T to rsp_valid at T+LOOKUP_LAT+2 (T+5 at default).
REQ-017 rsp_id SHALL be forced to 0 when the sampled ft_flow_hit=0.
REQ-018 On cfg accept, SHALL register the command and go to WRITE; WRITE SHALL drive ft_we=1 for exactly 5 consecutive cycles, beats k=0..3: ft_wdata=key[32k+31:32k]; beat 4: ft_wdata={15'b0, cfg_entry_valid, cfg_id}.
REQ-019 ft_waddr SHALL equal cfg_index for all 5 beats; the burst SHALL never be interrupted or split; return to IDLE after beat 4.
REQ-020 ft_we SHALL be 0 and ft_wdata/ft_waddr SHALL hold their values outside WRITE.
REQ-021 Simultaneous cfg_valid and req*_valid in IDLE SHALL result in cfg accept; the pending request SHALL be served in the next IDLE.
REQ-022 A beat counter SHALL be 3 bits, counting 0..4 and clearing on exit from WRITE.

Reset
REQ-023 While rst_n=0, SHALL hold: state IDLE, rr pointer 0, counters 0, all ready/valid/we outputs 0, rsp_*/ft_* data outputs 0, busy 0.
REQ-024 Reset mid-WRITE or mid-lookup SHALL abort the operation without completion; the flow table SHALL be reset together with this block.

Configuration
REQ-025 Macro FLOW_TABLE_STATS_EN SHALL add ports stats_clr in 1, hit_count out 32, miss_count out 32.
REQ-026 With FLOW_TABLE_STATS_EN defined, each RESP entry SHALL increment hit_count or miss_count, saturating at 32'hFFFFFFFF; stats_clr SHALL zero both, with clear winning over a same-cycle increment; both SHALL reset to 0.
REQ-027 Without FLOW_TABLE_STATS_EN, the stats ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-028 cfg index 8'h12, key 128'h0123..CDEF, id 16'h00AB, valid 1 -> ft_we 5 consecutive cycles, waddr 8'h12, beat 4 wdata 32'h000100AB.
REQ-029 req0 key matching the written entry, rsp_ready=1 -> rsp_valid at T+5, rsp_src 0, rsp_hit 1, rsp_id 16'h00AB.
REQ-030 req0 and req1 held valid continuously -> grants alternate 0,1,0,1; rsp_src sequence 0,1,0,1.
REQ-031 rsp_ready held 0 for 10 cycles in RESP -> rsp_* stable, no ready high, no ft_flow_key_valid; one response on release.
REQ-032 cfg_valid and req1_valid asserted in the same IDLE cycle -> write burst first, then req1 lookup; rst_n pulsed in the 3rd write beat -> ft_we 0 immediately, state IDLE.
REQ-033 FLOW_TABLE_STATS_EN defined, 3 hits and 2 misses -> hit_count 3, miss_count 2; stats_clr -> both 0 next cycle.
